// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg: loader state encoding, default network geometry
// and word width shared by the config loader blocks.
package nn_cfg_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int CFG_WORD_W = 2 * DEF_DATA_WIDTH;
    localparam int DEF_NUM_LAYERS = 3;

    localparam int DEF_NN_L1 = 30;
    localparam int DEF_NN_L2 = 30;
    localparam int DEF_NN_L3 = 10;
    localparam int DEF_NW_L1 = 784;
    localparam int DEF_NW_L2 = 30;
    localparam int DEF_NW_L3 = 30;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WEIGHT = 3'd1,
        ST_BIAS   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nn_cfg_index_counter.sv
// nn_cfg_index_counter: nested weight/neuron/layer position
// inside the config image, with last-of-level flags.
module nn_cfg_index_counter
    import nn_cfg_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int NN_L1 = DEF_NN_L1,
    parameter int NN_L2 = DEF_NN_L2,
    parameter int NN_L3 = DEF_NN_L3,
    parameter int NW_L1 = DEF_NW_L1,
    parameter int NW_L2 = DEF_NW_L2,
    parameter int NW_L3 = DEF_NW_L3,
    localparam int WC_W = $clog2(max3(NW_L1, NW_L2, NW_L3)) + 1,
    localparam int NC_W = $clog2(max3(NN_L1, NN_L2, NN_L3)) + 1
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_aresetn,
    input  logic            clear,
    input  logic            adv_weight,
    input  logic            adv_bias,
    output logic [1:0]      layer_idx,
    output logic [NC_W-1:0] neuron_idx,
    output logic [WC_W-1:0] weight_idx,
    output logic            last_weight,
    output logic            last_neuron,
    output logic            last_layer
);

    function automatic logic [WC_W-1:0] last_w_of(input logic [1:0] l);
        case (l)
            2'd0:    return WC_W'(NW_L1 - 1);
            2'd1:    return WC_W'(NW_L2 - 1);
            default: return WC_W'(NW_L3 - 1);
        endcase
    endfunction

    function automatic logic [NC_W-1:0] last_n_of(input logic [1:0] l);
        case (l)
            2'd0:    return NC_W'(NN_L1 - 1);
            2'd1:    return NC_W'(NN_L2 - 1);
            default: return NC_W'(NN_L3 - 1);
        endcase
    endfunction

    assign last_weight = (weight_idx == last_w_of(layer_idx));
    assign last_neuron = (neuron_idx == last_n_of(layer_idx));
    assign last_layer  = (layer_idx == 2'(NUM_LAYERS - 1));

    // After the final bias everything wraps to the first position.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            layer_idx  <= '0;
            neuron_idx <= '0;
            weight_idx <= '0;
        end else if (clear) begin
            layer_idx  <= '0;
            neuron_idx <= '0;
            weight_idx <= '0;
        end else if (adv_bias) begin
            weight_idx <= '0;
            if (last_neuron) begin
                neuron_idx <= '0;
                layer_idx  <= last_layer ? 2'd0 : layer_idx + 2'd1;
            end else begin
                neuron_idx <= neuron_idx + NC_W'(1);
            end
        end else if (adv_weight && !last_weight) begin
            weight_idx <= weight_idx + WC_W'(1);
        end
    end

endmodule

// File: rtl/nn_config_loader.sv
// nn_config_loader: streams the weight/bias image into the layer
// config ports. CFG_CHECKSUM_EN adds a trailing checksum word.
module nn_config_loader
    import nn_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_WORD_W / 2,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int NN_L1 = DEF_NN_L1,
    parameter int NN_L2 = DEF_NN_L2,
    parameter int NN_L3 = DEF_NN_L3,
    parameter int NW_L1 = DEF_NW_L1,
    parameter int NW_L2 = DEF_NW_L2,
    parameter int NW_L3 = DEF_NW_L3,
    localparam int W = 2 * DATA_WIDTH,
    localparam int WC_W = $clog2(max3(NW_L1, NW_L2, NW_L3)) + 1,
    localparam int NC_W = $clog2(max3(NN_L1, NN_L2, NN_L3)) + 1
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_aresetn,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    output logic [W-1:0] layer_num,
    output logic [W-1:0] neuron_num,
    output logic [W-1:0] weight_value,
    output logic         weight_valid,
    output logic [W-1:0] bias_value,
    output logic         bias_valid,
    output logic         busy,
    output logic         done,
    output logic         error
);

`ifdef CFG_CHECKSUM_EN
    localparam cfg_state_e ST_AFTER_IMAGE = ST_CHECK;
`else
    localparam cfg_state_e ST_AFTER_IMAGE = ST_DONE;
`endif

    cfg_state_e      state;
    logic            accept;
    logic            adv_weight;
    logic            adv_bias;
    logic            clear;
    logic [1:0]      layer_idx;
    logic [NC_W-1:0] neuron_idx;
    logic [WC_W-1:0] weight_idx;
    logic            last_weight;
    logic            last_neuron;
    logic            last_layer;

    assign cfg_ready  = (state == ST_WEIGHT) || (state == ST_BIAS) ||
                        (state == ST_CHECK);
    assign accept     = cfg_valid && cfg_ready;
    assign adv_weight = accept && !abort && (state == ST_WEIGHT);
    assign adv_bias   = accept && !abort && (state == ST_BIAS);
    assign clear      = abort || (start && (state == ST_IDLE));

    nn_cfg_index_counter #(
        .NUM_LAYERS (NUM_LAYERS),
        .NN_L1      (NN_L1),
        .NN_L2      (NN_L2),
        .NN_L3      (NN_L3),
        .NW_L1      (NW_L1),
        .NW_L2      (NW_L2),
        .NW_L3      (NW_L3)
    ) u_index (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .clear         (clear),
        .adv_weight    (adv_weight),
        .adv_bias      (adv_bias),
        .layer_idx     (layer_idx),
        .neuron_idx    (neuron_idx),
        .weight_idx    (weight_idx),
        .last_weight   (last_weight),
        .last_neuron   (last_neuron),
        .last_layer    (last_layer)
    );

`ifdef CFG_CHECKSUM_EN
    logic [W-1:0] csum;
    logic         error_q;

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state        <= ST_IDLE;
            layer_num    <= W'(1);
            neuron_num   <= '0;
            weight_value <= '0;
            weight_valid <= 1'b0;
            bias_value   <= '0;
            bias_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            csum         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                layer_num  <= W'(1);
                neuron_num <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_WEIGHT;
                            busy  <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                            csum    <= '0;
                            error_q <= 1'b0;
`endif
                        end
                    end
                    ST_WEIGHT: begin
                        if (accept) begin
                            weight_value <= cfg_data;
                            weight_valid <= 1'b1;
                            layer_num    <= W'(layer_idx) + W'(1);
                            neuron_num   <= W'(neuron_idx);
`ifdef CFG_CHECKSUM_EN
                            csum         <= csum + cfg_data;
`endif
                            if (last_weight)
                                state <= ST_BIAS;
                        end
                    end
                    ST_BIAS: begin
                        if (accept) begin
                            bias_value <= cfg_data;
                            bias_valid <= 1'b1;
                            layer_num  <= W'(layer_idx) + W'(1);
                            neuron_num <= W'(neuron_idx);
`ifdef CFG_CHECKSUM_EN
                            csum       <= csum + cfg_data;
`endif
                            if (last_neuron && last_layer)
                                state <= ST_AFTER_IMAGE;
                            else
                                state <= ST_WEIGHT;
                        end
                    end
`ifdef CFG_CHECKSUM_EN
                    ST_CHECK: begin
                        if (accept) begin
                            error_q <= (cfg_data != csum);
                            state   <= ST_DONE;
                        end
                    end
`endif
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_config_loader.sv
// tb_nn_config_loader: random image words checked against a
// position model of the layer -> neuron -> weights -> bias walk.
module tb_nn_config_loader;

    localparam int DW = 16;
    localparam int W  = 2 * DW;
    localparam int NL = 2;
    localparam int N1 = 2;
    localparam int W1 = 3;
    localparam int N2 = 1;
    localparam int W2 = 2;
    localparam int IMG = N1 * (W1 + 1) + N2 * (W2 + 1);
`ifdef CFG_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int TOT = IMG + CK;
    localparam int EXP_W = N1 * W1 + N2 * W2;
    localparam int EXP_B = N1 + N2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] layer_num;
    logic [W-1:0] neuron_num;
    logic [W-1:0] weight_value;
    logic         weight_valid;
    logic [W-1:0] bias_value;
    logic         bias_valid;
    logic         busy;
    logic         done;
    logic         error;

    nn_config_loader #(
        .DATA_WIDTH (DW),
        .NUM_LAYERS (NL),
        .NN_L1      (N1),
        .NN_L2      (N2),
        .NN_L3      (1),
        .NW_L1      (W1),
        .NW_L2      (W2),
        .NW_L3      (1)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .layer_num     (layer_num),
        .neuron_num    (neuron_num),
        .weight_value  (weight_value),
        .weight_valid  (weight_valid),
        .bias_value    (bias_value),
        .bias_valid    (bias_valid),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           b;
        int           l;
        int           n;
        logic [W-1:0] v;
    } ev_t;

    ev_t          expq[$];
    int           tests;
    int           fails;
    int           phase;
    int           words_acc;
    logic [W-1:0] sum_m;
    bit           exp_err;
    bit           exp_done;
    int           w_seen;
    int           b_seen;
    int           d_seen;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image position k -> (is_bias, layer 1-based, neuron).
    task automatic tag_of(input int k, output bit b, output int l,
                          output int n);
        int base;
        int nn;
        int nw;
        base = 0;
        b = 0;
        l = 0;
        n = 0;
        for (int li = 1; li <= NL; li++) begin
            nn = (li == 1) ? N1 : N2;
            nw = (li == 1) ? W1 : W2;
            if (k < base + nn * (nw + 1)) begin
                l = li;
                n = (k - base) / (nw + 1);
                b = ((k - base) % (nw + 1)) == nw;
                return;
            end
            base += nn * (nw + 1);
        end
    endtask

    task automatic monitor();
        ev_t e;
        chk("strobe_present", weight_valid | bias_valid,
            W'(expq.size() != 0));
        chk("strobe_overlap", weight_valid & bias_valid, 0);
        if ((weight_valid | bias_valid) === 1'b1 && expq.size() != 0) begin
            e = expq.pop_front();
            chk("kind", bias_valid, W'(e.b));
            chk("layer_num", layer_num, W'(e.l));
            chk("neuron_num", neuron_num, W'(e.n));
            chk("value", e.b ? bias_value : weight_value, e.v);
        end
        if (weight_valid === 1'b1) w_seen++;
        if (bias_valid === 1'b1) b_seen++;
        if (done === 1'b1) d_seen++;
        chk("done", done, W'(exp_done));
        chk("busy", busy, W'(phase != 0));
        chk("cfg_ready", cfg_ready, W'(phase == 1));
        chk("error", error, W'(exp_err));
    endtask

    task automatic tick();
        ev_t e;
        bit  acc;
        acc = (phase == 1) && cfg_valid && !abort;
        exp_done = (phase == 2) && !abort;
        if (abort) begin
            phase = 0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                words_acc = 0;
                sum_m = '0;
                exp_err = 0;
            end
        end else if (phase == 2) begin
            phase = 0;
        end else if (acc) begin
            if (words_acc < IMG) begin
                tag_of(words_acc, e.b, e.l, e.n);
                e.v = cfg_data;
                expq.push_back(e);
                sum_m += cfg_data;
            end else begin
                exp_err = (cfg_data != sum_m);
            end
            words_acc++;
            if (words_acc == TOT) phase = 2;
        end
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap_at, input int gap_len,
                        input int start_at, input bit bad_ck);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            if (words_acc == IMG)
                cfg_data = bad_ck ? ~sum_m : sum_m;
            else
                cfg_data = $urandom;
            start = (i == start_at);
            tick();
            start = 1'b0;
            if (i == gap_at) begin
                cfg_valid = 1'b0;
                cfg_data = $urandom;
                for (int g = 0; g < gap_len; g++) tick();
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        w_seen = 0;
        b_seen = 0;
        d_seen = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_layer"}, layer_num, 1);
        chk({tag, "_neuron"}, neuron_num, 0);
        chk({tag, "_wval"}, weight_value, 0);
        chk({tag, "_bval"}, bias_value, 0);
        chk({tag, "_wv"}, weight_valid, 0);
        chk({tag, "_bv"}, bias_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_ready"}, cfg_ready, 0);
    endtask

    task automatic chk_counts(input string tag, input int d);
        chk({tag, "_weights"}, W'(w_seen), W'(EXP_W));
        chk({tag, "_biases"}, W'(b_seen), W'(EXP_B));
        chk({tag, "_dones"}, W'(d_seen), W'(d));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        phase = 0;
        words_acc = 0;
        sum_m = '0;
        exp_err = 0;
        exp_done = 0;
        clr_counts();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        idle(2);

        clr_counts();
        pulse_start();
        feed(TOT, -1, 0, -1, 0);
        idle(3);
        chk_counts("t1", 1);

        clr_counts();
        pulse_start();
        feed(TOT, 1, 5, -1, 0);
        idle(3);
        chk_counts("t2", 1);

        clr_counts();
        pulse_start();
        feed(5, -1, 0, -1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(3);
        chk("t3_abort_dones", W'(d_seen), 0);
        clr_counts();
        pulse_start();
        feed(TOT, -1, 0, -1, 0);
        idle(3);
        chk_counts("t3_restart", 1);

        clr_counts();
        pulse_start();
        feed(TOT, -1, 0, 3, 0);
        idle(3);
        chk_counts("t4", 1);

`ifdef CFG_CHECKSUM_EN
        clr_counts();
        pulse_start();
        feed(TOT, 2, 2, -1, 1);
        idle(3);
        chk_counts("t5_bad", 1);
        chk("t5_err_sticky", error, 1);
        clr_counts();
        pulse_start();
        feed(TOT, -1, 0, -1, 0);
        idle(3);
        chk_counts("t5_good", 1);
`endif

        clr_counts();
        pulse_start();
        feed(4, -1, 0, -1, 0);
        cfg_valid = 1'b1;
        cfg_data = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        phase = 0;
        exp_err = 0;
        exp_done = 0;
        expq.delete();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("t6_hold");
        rst_n = 1'b1;
        idle(2);
        clr_counts();
        pulse_start();
        feed(TOT, -1, 0, -1, 0);
        idle(3);
        chk_counts("t6_reload", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
